// File: rtl/factorial_pkg.sv
// Shared constants for the factorial datapath: data width, op-codes and
// the sequential multiplier state encoding.
package factorial_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle for W cycles,
// then one WB cycle during which done flags the full 2W-bit product as valid.
module seq_multiplier
    import factorial_pkg::*;
#(
    parameter int W = factorial_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   prod
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    mul_state_t        state_reg, state_next;
    logic [2*W-1:0]    mcand_reg;
    logic [2*W-1:0]    acc_reg;
    logic [W-1:0]      mplier_reg;
    logic [CW-1:0]     cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == CNT_LAST) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                mcand_reg  <= {{W{1'b0}}, a};
                mplier_reg <= b;
                acc_reg    <= '0;
                cnt_reg    <= '0;
            end
        end else if (state_reg == RUN) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == WB);
    assign prod = acc_reg;

endmodule

// File: rtl/factorial_datapath.sv
// Datapath for the factorial controller: 4x32 register file, single-cycle ALU
// and a sequential multiplier sharing the one register write port.
module factorial_datapath #(
    parameter int WIDTH = factorial_pkg::WIDTH,
    parameter int NREGS = factorial_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_en,
    input  logic                     wd_selec,
    input  logic                     read_imm,
    input  logic [$clog2(NREGS)-1:0] read_add1,
    input  logic [$clog2(NREGS)-1:0] read_add2,
    input  logic [$clog2(NREGS)-1:0] write_add,
    input  logic [2:0]               operation,
    input  logic [WIDTH-1:0]         imm,
    output logic                     busy,
    output logic                     done,
    output logic                     mul_ovf,
    output logic                     is_zero,
    output logic [WIDTH-1:0]         result
);

    import factorial_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0]   regs_reg [NREGS];
    logic [WIDTH-1:0]   rd1, rd2, op_b, alu_out, cmd_data;
    logic               accept, is_mul_cmd, mul_start, cmd_wr;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [AW-1:0]      dest_reg;
    logic               done_reg, mul_ovf_reg;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_data;

    assign rd1  = regs_reg[read_add1];
    assign rd2  = regs_reg[read_add2];
    assign op_b = read_imm ? imm : rd2;

    always_comb begin
        alu_out = '0;
        case (operation)
            OP_ADD:   alu_out = rd1 + op_b;
            OP_SUB:   alu_out = rd1 - op_b;
            OP_AND:   alu_out = rd1 & op_b;
            OP_OR:    alu_out = rd1 | op_b;
            OP_XOR:   alu_out = rd1 ^ op_b;
            OP_PASSA: alu_out = rd1;
            OP_PASSB: alu_out = op_b;
            default:  alu_out = '0;
        endcase
    end

    // Commands are dropped, not queued, while the multiplier owns the datapath.
    assign accept     = write_en && !mul_busy;
    assign is_mul_cmd = !wd_selec && (operation == OP_MUL);
    assign mul_start  = accept && is_mul_cmd;
    assign cmd_wr     = accept && !is_mul_cmd;
    assign cmd_data   = wd_selec ? imm : alu_out;

    seq_multiplier #(.W(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (rd1),
        .b     (op_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // WB and an accepted command are mutually exclusive, so a simple mux suffices.
    assign wr_en   = cmd_wr || mul_done;
    assign wr_addr = mul_done ? dest_reg : write_add;
    assign wr_data = mul_done ? mul_prod[WIDTH-1:0] : cmd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_addr == AW'(i)) begin
                    regs_reg[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_reg    <= '0;
            done_reg    <= 1'b0;
            mul_ovf_reg <= 1'b0;
        end else begin
            done_reg <= mul_done;
            if (mul_start) begin
                dest_reg    <= write_add;
                mul_ovf_reg <= 1'b0;
            end else if (mul_done) begin
                mul_ovf_reg <= |mul_prod[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign busy    = mul_busy;
    assign done    = done_reg;
    assign mul_ovf = mul_ovf_reg;
    assign result  = rd1;
    assign is_zero = (rd1 == '0);

endmodule

// File: tb/tb_factorial_datapath.sv
// Directed self-checking bench for factorial_datapath: reset, ALU ops,
// multiplier timing/handshake, factorial loop, overflow and reset mid-MUL.
module tb_factorial_datapath;
    import factorial_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_en = 1'b0;
    logic        wd_selec = 1'b0;
    logic        read_imm = 1'b0;
    logic [1:0]  read_add1 = 2'd0;
    logic [1:0]  read_add2 = 2'd0;
    logic [1:0]  write_add = 2'd0;
    logic [2:0]  operation = 3'd0;
    logic [31:0] imm = 32'd0;
    logic        busy, done, mul_ovf, is_zero;
    logic [31:0] result;

    int compared = 0;
    int mismatched = 0;

    localparam logic [2:0]  ALU_OPS [7] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASSA, OP_PASSB};
    localparam logic [31:0] ALU_EXP [7] = '{32'h00E0_100E, 32'hE0FF_F1F0, 32'h00F0_000F, 32'hFFF0_0FFF,
                                            32'hFF00_0FF0, 32'hF0F0_00FF, 32'h0FF0_0F0F};

    factorial_datapath dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write_en  (write_en),
        .wd_selec  (wd_selec),
        .read_imm  (read_imm),
        .read_add1 (read_add1),
        .read_add2 (read_add2),
        .write_add (write_add),
        .operation (operation),
        .imm       (imm),
        .busy      (busy),
        .done      (done),
        .mul_ovf   (mul_ovf),
        .is_zero   (is_zero),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Present one command for one edge, then drop write_en and X the don't-cares.
    task automatic cmd(input logic wsel, input logic rimm, input logic [1:0] a1, input logic [1:0] a2,
                       input logic [1:0] wa, input logic [2:0] op, input logic [31:0] im);
        @(negedge clk);
        write_en = 1'b1; wd_selec = wsel; read_imm = rimm; read_add1 = a1; read_add2 = a2;
        write_add = wa; operation = op; imm = im;
        @(posedge clk); #1;
        write_en = 1'b0; wd_selec = 1'bx; read_imm = 1'bx; read_add2 = 2'bxx;
        write_add = 2'bxx; operation = 3'bxxx; imm = 32'hxxxx_xxxx;
        $display("cmd wsel=%0b rimm=%0b op=%0d a1=%0d a2=%0d wa=%0d imm=%h", wsel, rimm, op, a1, a2, wa, im);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v, output logic z);
        read_add1 = a;
        #1;
        v = result;
        z = is_zero;
    endtask

    task automatic run_mul(input logic rimm, input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] wa,
                           input logic [31:0] im, input bit conflict,
                           output int n_busy, output int n_done, output logic ended_done);
        cmd(1'b0, rimm, a1, a2, wa, OP_MUL, im);
        n_busy = 0;
        n_done = 0;
        for (int k = 0; k < 100 && busy === 1'b1; k++) begin
            n_busy++;
            if (conflict && k == 10) begin
                write_en = 1'b1; wd_selec = 1'b0; read_imm = 1'b1; read_add1 = wa;
                write_add = wa; operation = OP_ADD; imm = 32'd100;
            end else begin
                write_en = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        write_en = 1'b0;
        ended_done = done;
        @(posedge clk); #1;
        if (done === 1'b1) n_done++;
        $display("mul a1=%0d a2=%0d wa=%0d busy_cycles=%0d done_pulses=%0d", a1, a2, wa, n_busy, n_done);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic z;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
        compared++; if (mul_ovf !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %b expected 0", mul_ovf); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i[1:0], v, z);
            compared++; if (v !== 32'd0) begin mismatched++; $display("FAIL reset_reg%0d: got %h expected 0", i, v); end
            compared++; if (z !== 1'b1) begin mismatched++; $display("FAIL reset_zero%0d: got %b expected 1", i, z); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_imm_sub();
        logic [31:0] v;
        logic z;
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, OP_MUL, 32'd5);
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd1, OP_ADD, 32'd1);
        read_reg(2'd1, v, z);
        compared++; if (v !== 32'd1) begin mismatched++; $display("FAIL imm_r1: got %h expected 1", v); end
        @(negedge clk);
        write_en = 1'b1; wd_selec = 1'b0; read_imm = 1'b1; read_add1 = 2'd0;
        write_add = 2'd0; operation = OP_SUB; imm = 32'd1;
        #1;
        compared++; if (result !== 32'd5) begin mismatched++; $display("FAIL rdw_old: got %h expected 5", result); end
        @(posedge clk); #1;
        write_en = 1'b0;
        compared++; if (result !== 32'd4) begin mismatched++; $display("FAIL sub_r0: got %h expected 4", result); end
        $display("sub R0 = R0 - 1 -> %h", result);
    endtask

    task automatic test_alu();
        logic [31:0] v;
        logic z;
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd2, OP_ADD, 32'hF0F0_00FF);
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd3, OP_ADD, 32'h0FF0_0F0F);
        for (int i = 0; i < 7; i++) begin
            cmd(1'b0, 1'b0, 2'd2, 2'd3, 2'd0, ALU_OPS[i], 32'd0);
            read_reg(2'd0, v, z);
            compared++;
            if (v !== ALU_EXP[i]) begin
                mismatched++; $display("FAIL alu_op%0d: got %h expected %h", ALU_OPS[i], v, ALU_EXP[i]);
            end
        end
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, OP_ADD, 32'd0);
        read_reg(2'd0, v, z);
        compared++; if (z !== 1'b1) begin mismatched++; $display("FAIL zero_flag: got %b expected 1", z); end
        cmd(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, OP_SUB, 32'd1);
        read_reg(2'd0, v, z);
        compared++; if (v !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL sub_wrap: got %h expected ffffffff", v); end
        compared++; if (z !== 1'b0) begin mismatched++; $display("FAIL wrap_zero: got %b expected 0", z); end
    endtask

    task automatic test_mul();
        logic [31:0] v;
        logic z, ed;
        int nb, nd;
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, OP_ADD, 32'd5);
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd1, OP_ADD, 32'd1);
        run_mul(1'b0, 2'd0, 2'd1, 2'd1, 32'd0, 1'b1, nb, nd, ed);
        compared++; if (nb !== 33) begin mismatched++; $display("FAIL mul_busy_len: got %0d expected 33", nb); end
        compared++; if (ed !== 1'b1) begin mismatched++; $display("FAIL mul_done_timing: got %b expected 1", ed); end
        compared++; if (nd !== 1) begin mismatched++; $display("FAIL mul_done_count: got %0d expected 1", nd); end
        compared++; if (mul_ovf !== 1'b0) begin mismatched++; $display("FAIL mul_ovf_small: got %b expected 0", mul_ovf); end
        read_reg(2'd1, v, z);
        compared++; if (v !== 32'd5) begin mismatched++; $display("FAIL mul_r1: got %h expected 5", v); end
    endtask

    task automatic test_factorial();
        logic [31:0] v;
        logic z, ed;
        int nb, nd, iters;
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, OP_ADD, 32'd5);
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd1, OP_ADD, 32'd1);
        iters = 0;
        z = 1'b0;
        while (z !== 1'b1 && iters < 10) begin
            run_mul(1'b0, 2'd1, 2'd0, 2'd1, 32'd0, 1'b0, nb, nd, ed);
            cmd(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, OP_SUB, 32'd1);
            read_reg(2'd0, v, z);
            iters++;
        end
        compared++; if (iters !== 5) begin mismatched++; $display("FAIL fact_iters: got %0d expected 5", iters); end
        compared++; if (z !== 1'b1) begin mismatched++; $display("FAIL fact_zero: got %b expected 1", z); end
        compared++; if (v !== 32'd0) begin mismatched++; $display("FAIL fact_r0: got %h expected 0", v); end
        read_reg(2'd1, v, z);
        compared++; if (v !== 32'd120) begin mismatched++; $display("FAIL fact_r1: got %0d expected 120", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic z, ed;
        int nb, nd;
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd2, OP_ADD, 32'h0001_0000);
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd3, OP_ADD, 32'h0001_0000);
        run_mul(1'b0, 2'd2, 2'd3, 2'd2, 32'd0, 1'b0, nb, nd, ed);
        compared++; if (mul_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b expected 1", mul_ovf); end
        read_reg(2'd2, v, z);
        compared++; if (v !== 32'd0) begin mismatched++; $display("FAIL ovf_low: got %h expected 0", v); end
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd2, OP_ADD, 32'd3);
        compared++; if (mul_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_hold: got %b expected 1", mul_ovf); end
        run_mul(1'b1, 2'd2, 2'd0, 2'd2, 32'd4, 1'b0, nb, nd, ed);
        compared++; if (mul_ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b expected 0", mul_ovf); end
        read_reg(2'd2, v, z);
        compared++; if (v !== 32'd12) begin mismatched++; $display("FAIL mul_3x4: got %0d expected 12", v); end
    endtask

    task automatic test_reset_during_mul();
        logic [31:0] v;
        logic z;
        int nd;
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd2, OP_ADD, 32'd6);
        cmd(1'b1, 1'b0, 2'd0, 2'd0, 2'd3, OP_ADD, 32'd7);
        cmd(1'b0, 1'b0, 2'd2, 2'd3, 2'd1, OP_MUL, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        write_en = 1'b1; wd_selec = 1'b1; write_add = 2'd2; imm = 32'd9;
        @(posedge clk); #1;
        write_en = 1'b0;
        $display("cmd after reset release: imm 9 -> R2");
        read_reg(2'd2, v, z);
        compared++; if (v !== 32'd9) begin mismatched++; $display("FAIL post_rst_accept: got %h expected 9", v); end
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        compared++; if (nd !== 0) begin mismatched++; $display("FAIL rst_mid_done: got %0d expected 0", nd); end
        read_reg(2'd1, v, z);
        compared++; if (v !== 32'd0) begin mismatched++; $display("FAIL rst_mid_dest: got %h expected 0", v); end
        read_reg(2'd3, v, z);
        compared++; if (v !== 32'd0) begin mismatched++; $display("FAIL rst_mid_r3: got %h expected 0", v); end
    endtask

    initial begin
        test_reset();
        test_imm_sub();
        test_alu();
        test_mul();
        test_factorial();
        test_overflow();
        test_reset_during_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
